// File: rtl/multi_random_state_generator_pkg.sv
// random_state_gen_pkg
//   Shared definitions for the multi-channel random state generator:
//   the mode encoding, the LFSR polynomial, the per-channel seed spreading
//   constant and the two helper functions used to derive seeds and step
//   the 32-bit Galois LFSR.
package random_state_gen_pkg;

    typedef enum logic [1:0] {
        RS_RANDOM     = 2'd0,
        RS_FIXED      = 2'd1,
        RS_FORCE_LOW  = 2'd2,
        RS_FORCE_HIGH = 2'd3
    } rs_mode_t;

    localparam logic [31:0] LFSR_POLY   = 32'h80200003;
    localparam logic [31:0] SEED_SPREAD = 32'h9E3779B9;

    // Spread the base seed across channels; an all-zero LFSR would lock up,
    // so a zero result is replaced by 1.
    function automatic logic [31:0] derive_seed(input logic [31:0] seed,
                                                input int unsigned c);
        logic [31:0] s;
        s = seed ^ (32'(c) * SEED_SPREAD);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    // Right-shifting Galois LFSR: the bit shifted out selects the feedback.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
    endfunction

endpackage

// File: rtl/multi_random_state_generator_channel.sv
// random_state_channel
//   One output channel: phase counter, phase length register, 32-bit LFSR
//   and the output bit.
//   i_clk     : clock
//   i_s_rst   : synchronous active-high reset
//   i_en      : advance enable (low freezes everything, toggle reads 0)
//   i_mode    : RANDOM / FIXED / FORCE_LOW / FORCE_HIGH
//   o_state   : channel output bit (registered)
//   o_toggle  : one-cycle pulse when o_state changes (registered)
module random_state_channel
    import random_state_gen_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned STATE_0_MIN_VAL = 10,
    parameter int unsigned STATE_0_MAX_VAL = 20,
    parameter int unsigned STATE_1_MIN_VAL = 30,
    parameter int unsigned STATE_1_MAX_VAL = 40,
    parameter logic [31:0] SEED            = 32'h1
) (
    input  logic     i_clk,
    input  logic     i_s_rst,
    input  logic     i_en,
    input  rs_mode_t i_mode,
    output logic     o_state,
    output logic     o_toggle
);

    localparam logic [31:0] RANGE_0 = 32'(STATE_0_MAX_VAL - STATE_0_MIN_VAL + 1);
    localparam logic [31:0] RANGE_1 = 32'(STATE_1_MAX_VAL - STATE_1_MIN_VAL + 1);
    localparam logic [CNT_WIDTH-1:0] MIN_0 = CNT_WIDTH'(STATE_0_MIN_VAL);
    localparam logic [CNT_WIDTH-1:0] MIN_1 = CNT_WIDTH'(STATE_1_MIN_VAL);

    // Random phase length for the state being entered; the modulus is a
    // constant so this reduces to fixed logic.
    function automatic logic [CNT_WIDTH-1:0] f_draw(input logic i_high,
                                                    input logic [CNT_WIDTH-1:0] i_bits);
        logic [31:0] w_b;
        w_b = 32'(i_bits);
        if (i_high) return CNT_WIDTH'(32'(STATE_1_MIN_VAL) + (w_b % RANGE_1));
        else        return CNT_WIDTH'(32'(STATE_0_MIN_VAL) + (w_b % RANGE_0));
    endfunction

    logic                 r_state;
    logic                 r_toggle;
    logic                 r_forced;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_len;
    logic [31:0]          r_lfsr;

    logic                 w_state_n;
    logic                 w_toggle_n;
    logic                 w_forced_n;
    logic [CNT_WIDTH-1:0] w_cnt_n;
    logic [CNT_WIDTH-1:0] w_len_n;
    logic [31:0]          w_lfsr_n;
    logic                 w_do_draw;
    logic                 w_draw_high;
    logic                 w_force_val;
    logic                 w_fixed;

    assign w_fixed = (i_mode == RS_FIXED);

    always_comb begin
        w_state_n   = r_state;
        w_toggle_n  = 1'b0;
        w_forced_n  = r_forced;
        w_cnt_n     = r_cnt;
        w_len_n     = r_len;
        w_lfsr_n    = r_lfsr;
        w_do_draw   = 1'b0;
        w_draw_high = 1'b0;
        w_force_val = (i_mode == RS_FORCE_HIGH);
        if (i_en) begin
            if (i_mode == RS_FORCE_LOW || i_mode == RS_FORCE_HIGH) begin
                w_state_n  = w_force_val;
                w_toggle_n = (r_state != w_force_val);
                w_cnt_n    = '0;
                w_forced_n = 1'b1;
            end else if (r_forced) begin
                // Leaving a forced mode: the held value starts a fresh phase.
                w_forced_n  = 1'b0;
                w_cnt_n     = '0;
                w_do_draw   = 1'b1;
                w_draw_high = r_state;
            end else if (r_cnt == r_len - CNT_WIDTH'(1)) begin
                w_state_n   = ~r_state;
                w_toggle_n  = 1'b1;
                w_cnt_n     = '0;
                w_do_draw   = 1'b1;
                w_draw_high = ~r_state;
            end else begin
                w_cnt_n = r_cnt + CNT_WIDTH'(1);
            end
            if (w_do_draw) begin
                if (w_fixed) begin
                    w_len_n = w_draw_high ? MIN_1 : MIN_0;
                end else begin
                    w_len_n  = f_draw(w_draw_high, r_lfsr[CNT_WIDTH-1:0]);
                    w_lfsr_n = lfsr_step(r_lfsr);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            // The first LOW length is drawn from the seed itself; FORCE
            // modes draw as RANDOM here.
            r_state  <= 1'b0;
            r_toggle <= 1'b0;
            r_forced <= 1'b0;
            r_cnt    <= '0;
            if (w_fixed) begin
                r_len  <= MIN_0;
                r_lfsr <= SEED;
            end else begin
                r_len  <= f_draw(1'b0, SEED[CNT_WIDTH-1:0]);
                r_lfsr <= lfsr_step(SEED);
            end
        end else begin
            r_state  <= w_state_n;
            r_toggle <= w_toggle_n;
            r_forced <= w_forced_n;
            r_cnt    <= w_cnt_n;
            r_len    <= w_len_n;
            r_lfsr   <= w_lfsr_n;
        end
    end

    assign o_state  = r_state;
    assign o_toggle = r_toggle;

endmodule

// File: rtl/multi_random_state_generator.sv
// multi_random_state_generator
//   CHANNELS independent 0/1 outputs whose phase lengths are drawn from
//   per-channel LFSRs (RANDOM), fixed at the minimum (FIXED), or forced.
//   i_clk     : clock
//   i_s_rst   : synchronous active-high reset
//   i_en      : advance enable for all channels
//   i_mode    : 0 RANDOM, 1 FIXED, 2 FORCE_LOW, 3 FORCE_HIGH (all channels)
//   o_state   : channel outputs (registered)
//   o_toggle  : per-channel change pulse (registered)
module multi_random_state_generator
    import random_state_gen_pkg::*;
#(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned STATE_0_MIN_VAL = 10,
    parameter int unsigned STATE_0_MAX_VAL = 20,
    parameter int unsigned STATE_1_MIN_VAL = 30,
    parameter int unsigned STATE_1_MAX_VAL = 40,
    parameter logic [31:0] SEED            = 32'hACE1
) (
    input  logic                i_clk,
    input  logic                i_s_rst,
    input  logic                i_en,
    input  logic [1:0]          i_mode,
    output logic [CHANNELS-1:0] o_state,
    output logic [CHANNELS-1:0] o_toggle
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_err_channels
        $error("CHANNELS must be in 1..32");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_err_width
        $error("CNT_WIDTH must be in 1..32");
    end
    if (STATE_0_MIN_VAL < 1 || STATE_1_MIN_VAL < 1) begin : g_err_min
        $error("state minimum lengths must be at least 1");
    end
    if (STATE_0_MIN_VAL > STATE_0_MAX_VAL || STATE_1_MIN_VAL > STATE_1_MAX_VAL) begin : g_err_order
        $error("state minimum length exceeds maximum");
    end
    if (64'(STATE_0_MAX_VAL) >= (64'd1 << CNT_WIDTH) ||
        64'(STATE_1_MAX_VAL) >= (64'd1 << CNT_WIDTH)) begin : g_err_max
        $error("state maximum length does not fit CNT_WIDTH");
    end

    rs_mode_t w_mode;
    assign w_mode = rs_mode_t'(i_mode);

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        random_state_channel #(
            .CNT_WIDTH      (CNT_WIDTH),
            .STATE_0_MIN_VAL(STATE_0_MIN_VAL),
            .STATE_0_MAX_VAL(STATE_0_MAX_VAL),
            .STATE_1_MIN_VAL(STATE_1_MIN_VAL),
            .STATE_1_MAX_VAL(STATE_1_MAX_VAL),
            .SEED           (derive_seed(SEED, g))
        ) u_ch (
            .i_clk   (i_clk),
            .i_s_rst (i_s_rst),
            .i_en    (i_en),
            .i_mode  (w_mode),
            .o_state (o_state[g]),
            .o_toggle(o_toggle[g])
        );
    end

endmodule

// File: tb/tb_multi_random_state_generator.sv
// Bench for multi_random_state_generator: a default 4-channel instance and a
// 1-channel instance with SEED=0 and 1-cycle HIGH phases, sharing inputs.
module tb_multi_random_state_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [1:0] mode = 2'd1;
    logic [3:0] o_state, o_toggle;
    logic [0:0] d1_state, d1_toggle;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [4][$];
    logic [15:0] d1_q [$];
    int          run_len [4];
    int          d1_len;
    logic [3:0]  prev_state;
    logic        d1_prev;
    logic [3:0]  trace [2000];
    bit          diff_seen;
    int          mism;

    always #5 clk = ~clk;

    multi_random_state_generator #(
        .CHANNELS(4), .CNT_WIDTH(16),
        .STATE_0_MIN_VAL(10), .STATE_0_MAX_VAL(20),
        .STATE_1_MIN_VAL(30), .STATE_1_MAX_VAL(40),
        .SEED(32'hACE1)
    ) u_dut (
        .i_clk(clk), .i_s_rst(rst), .i_en(en), .i_mode(mode),
        .o_state(o_state), .o_toggle(o_toggle)
    );

    multi_random_state_generator #(
        .CHANNELS(1), .CNT_WIDTH(16),
        .STATE_0_MIN_VAL(10), .STATE_0_MAX_VAL(20),
        .STATE_1_MIN_VAL(1), .STATE_1_MAX_VAL(1),
        .SEED(32'h0)
    ) u_dut1 (
        .i_clk(clk), .i_s_rst(rst), .i_en(en), .i_mode(mode),
        .o_state(d1_state), .o_toggle(d1_toggle)
    );

    // Independent reference of the LFSR and seed spreading.
    function automatic logic [31:0] m_step(input logic [31:0] x);
        logic [31:0] y;
        y = {1'b0, x[31:1]};
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    function automatic logic [31:0] m_seed(input int c);
        logic [31:0] s;
        s = 32'hACE1 ^ (32'(c) * 32'h9E3779B9);
        if (s == 0) s = 32'd1;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected run-length sequence per channel, starting with the first LOW.
    task automatic prefill(input bit fixed);
        logic [31:0] lf;
        logic        st;
        logic [15:0] len;
        for (int c = 0; c < 4; c++) begin
            exp_q[c].delete();
            lf = m_seed(c);
            st = 1'b0;
            for (int k = 0; k < 400; k++) begin
                if (fixed) begin
                    len = st ? 16'd30 : 16'd10;
                end else begin
                    len = st ? (16'd30 + (lf[15:0] % 16'd11)) : (16'd10 + (lf[15:0] % 16'd11));
                    lf  = m_step(lf);
                end
                exp_q[c].push_back(len);
                st = ~st;
            end
        end
        d1_q.delete();
        if (fixed) d1_q = '{16'd10, 16'd1, 16'd10, 16'd1, 16'd10};
        else       d1_q = '{16'd11, 16'd1, 16'd12, 16'd1, 16'd13};
    endtask

    task automatic do_reset(input logic [1:0] m);
        mode = m;
        en   = 1'b1;
        rst  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_state", 32'(o_state), 32'h0);
        check("rst_toggle", 32'(o_toggle), 32'h0);
        check("rst_d1_state", 32'(d1_state), 32'h0);
        for (int c = 0; c < 4; c++) run_len[c] = 1;
        d1_len     = 1;
        prev_state = 4'h0;
        d1_prev    = 1'b0;
    endtask

    task automatic run_monitored(input int n, input bit rec, input bit cmp);
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rec) trace[i] = o_state;
            if (cmp && trace[i] !== o_state) mism++;
            if (o_state[0] != o_state[1]) diff_seen = 1'b1;
            for (int c = 0; c < 4; c++) begin
                check("toggle_edge", 32'(o_toggle[c]), 32'(o_state[c] ^ prev_state[c]));
                if (o_toggle[c]) begin
                    e = (exp_q[c].size() > 0) ? exp_q[c].pop_front() : 16'hFFFF;
                    check($sformatf("run_len_ch%0d", c), 32'(run_len[c]), 32'(e));
                    if (prev_state[c]) check("high_bound", 32'(run_len[c] >= 30 && run_len[c] <= 40), 32'd1);
                    else               check("low_bound",  32'(run_len[c] >= 10 && run_len[c] <= 20), 32'd1);
                    run_len[c] = 1;
                end else begin
                    run_len[c]++;
                end
            end
            prev_state = o_state;
            if (d1_toggle[0]) begin
                if (d1_q.size() > 0) check("d1_run_len", 32'(d1_len), 32'(d1_q.pop_front()));
                d1_len = 1;
            end else begin
                d1_len++;
            end
            check("d1_toggle_edge", 32'(d1_toggle[0]), 32'(d1_state[0] ^ d1_prev));
            d1_prev = d1_state[0];
        end
    endtask

    initial begin
        // FIXED: 10 LOW, 30 HIGH repeating on every channel.
        prefill(1'b1);
        do_reset(2'd1);
        run_monitored(200, 1'b0, 1'b0);

        // RANDOM: model-matched run lengths, recorded trace.
        prefill(1'b0);
        diff_seen = 1'b0;
        do_reset(2'd0);
        run_monitored(2000, 1'b1, 1'b0);
        check("channels_differ", 32'(diff_seen), 32'd1);

        // Same seed after a fresh reset reproduces the trace.
        prefill(1'b0);
        mism = 0;
        do_reset(2'd0);
        run_monitored(2000, 1'b0, 1'b1);
        check("repro_mismatches", 32'(mism), 32'd0);

        // Hand-derived first LOW lengths 14/11/13/10 and ch0 first HIGH 40.
        do_reset(2'd0);
        for (int j = 1; j <= 54; j++) begin
            tick();
            case (j)
                9:  check("rnd_j9",  32'(o_state), 32'b0000);
                10: begin check("rnd_j10", 32'(o_state), 32'b1000); check("rnd_t10", 32'(o_toggle), 32'b1000); end
                11: check("rnd_j11", 32'(o_state), 32'b1010);
                12: check("rnd_j12", 32'(o_state), 32'b1010);
                13: check("rnd_j13", 32'(o_state), 32'b1110);
                14: begin check("rnd_j14", 32'(o_state), 32'b1111); check("rnd_t14", 32'(o_toggle), 32'b0001); end
                53: check("rnd_ch0_j53", 32'(o_state[0]), 32'd1);
                54: begin check("rnd_ch0_j54", 32'(o_state[0]), 32'd0); check("rnd_ch0_t54", 32'(o_toggle[0]), 32'd1); end
                default: ;
            endcase
        end

        // Freeze for 7 cycles mid LOW phase stretches it by 7.
        do_reset(2'd1);
        repeat (5) tick();
        en = 1'b0;
        for (int j = 0; j < 7; j++) begin
            tick();
            check("frz_toggle", 32'(o_toggle), 32'h0);
            check("frz_state", 32'(o_state), 32'h0);
        end
        en = 1'b1;
        repeat (4) tick();
        check("frz_j16_state", 32'(o_state), 32'h0);
        tick();
        check("frz_j17_state", 32'(o_state), 32'hF);
        check("frz_j17_toggle", 32'(o_toggle), 32'hF);

        // FORCE_HIGH sampled at edge 6, then back to FIXED.
        do_reset(2'd1);
        repeat (5) tick();
        mode = 2'd3;
        tick();
        check("frc_state", 32'(o_state), 32'hF);
        check("frc_toggle", 32'(o_toggle), 32'hF);
        mode = 2'd1;
        tick();
        check("frc_exit_state", 32'(o_state), 32'hF);
        check("frc_exit_toggle", 32'(o_toggle), 32'h0);
        repeat (29) tick();
        check("frc_high_j36", 32'(o_state), 32'hF);
        tick();
        check("frc_low_j37", 32'(o_state), 32'h0);
        check("frc_low_t37", 32'(o_toggle), 32'hF);
        repeat (9) tick();
        check("frc_low_j46", 32'(o_state), 32'h0);
        tick();
        check("frc_high_j47", 32'(o_state), 32'hF);
        mode = 2'd2;
        tick();
        check("flow_state", 32'(o_state), 32'h0);
        check("flow_toggle", 32'(o_toggle), 32'hF);
        tick();
        check("flow_hold_state", 32'(o_state), 32'h0);
        check("flow_hold_toggle", 32'(o_toggle), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_random_state_generator.md
# multi_random_state_generator

Synthesizable, multi-channel successor of the testbench random state generator. Each of `CHANNELS` independent outputs alternates between 0 and 1. The length of each phase is drawn from a per-channel 32-bit LFSR within parameterised bounds. Additional modes give fixed-period and forced output. It drives stimulus such as random `tvalid`/`tready` throttling and line toggling, both in simulation and on the Hyperion board for hardware-in-the-loop tests.

## Interface
- `CHANNELS`, 4: number of independent outputs (1..32).
- `CNT_WIDTH`, 16: width of the phase counter and the drawn length.
- `STATE_0_MIN_VAL`, 10: minimum LOW phase length, in cycles.
- `STATE_0_MAX_VAL`, 20: maximum LOW phase length, in cycles.
- `STATE_1_MIN_VAL`, 30: minimum HIGH phase length, in cycles.
- `STATE_1_MAX_VAL`, 40: maximum HIGH phase length, in cycles.
- `SEED`, 32'hACE1: base LFSR seed.
- `i_clk` input 1: clock. One clock; reset is synchronous and active-high.
- `i_s_rst` input 1: synchronous, active-high reset.
- `i_en` input 1: advance enable. When low, all state and outputs freeze.
- `i_mode` input 2: 0 RANDOM, 1 FIXED, 2 FORCE_LOW, 3 FORCE_HIGH. Applies to all channels.
- `o_state` output CHANNELS: channel outputs.
- `o_toggle` output CHANNELS: one-cycle pulse in the cycle the matching `o_state` bit changes.

## Operation
- Per-channel seed: `s_c = SEED ^ (c * 32'h9E3779B9)`. If `s_c` is 0, use `32'h1` instead.
- LFSR: 32-bit Galois, polynomial `32'h80200003`. It advances exactly once per draw.
- Draw in RANDOM mode: `L = MIN + (lfsr[CNT_WIDTH-1:0] % (MAX-MIN+1))`.
  - MIN/MAX are those of the state being entered.
  - The modulus is a constant, so it synthesises.
  - L lies in [MIN, MAX].
- Draw in FIXED mode: `L = MIN` of the state being entered. The LFSR does not advance.
- Phase rule: once entered, a state holds for exactly L enabled cycles. It then toggles and a new L is drawn for the new state.
- Reset:
  - `o_state` = 0, `o_toggle` = 0, counters = 0.
  - LFSR is loaded with `s_c`, and the first LOW length is drawn from `s_c`, so the LFSR holds `step(s_c)`.
  - The mode used for this draw is `i_mode` as sampled during reset. FORCE modes are treated as RANDOM for this draw.
- `i_en` = 0: counters, LFSR, `o_state` and `i_mode` effects are all held. `o_toggle` = 0.
- FORCE_LOW / FORCE_HIGH:
  - `o_state` goes to the forced value on the next enabled edge.
  - `o_toggle` pulses only on channels whose value changes.
  - The counter is held at 0 and no draws occur.
- Leaving a FORCE mode: the current `o_state` value starts a fresh phase with a newly drawn L, using the new mode.
- Switching between RANDOM and FIXED takes effect at the next draw. The current phase completes unchanged.
- Reset mid-phase: discards all state. The seed sequence restarts identically, so runs are reproducible.
- Elaboration error if any of these fail:
  - MIN ≥ 1
  - MIN ≤ MAX
  - MAX < 2**CNT_WIDTH
  - 1 ≤ CHANNELS ≤ 32

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- Deassertion of `i_s_rst` at edge k: the first LOW cycle is the cycle after edge k. With `i_en` = 1 and a first LOW length L0, `o_state` rises at edge k+L0.
- `o_toggle` is asserted in the same cycle that the new `o_state` value first appears.
- Mode change to FORCE_x sampled at edge n: the forced value appears after edge n, i.e. 1-cycle latency.
- Phase counter compare: `cnt == L-1` triggers the toggle on the next edge. `cnt` is CNT_WIDTH wide and never wraps, because L ≤ 2**CNT_WIDTH-1.
- Draw, LFSR step and toggle all happen on the same edge. There is no bubble between phases.

## Structure
- Package `random_state_gen_pkg`:
  - mode enum `rs_mode_t` (RS_RANDOM, RS_FIXED, RS_FORCE_LOW, RS_FORCE_HIGH)
  - `LFSR_POLY`
  - `SEED_SPREAD` (`32'h9E3779B9`)
  - function `derive_seed(seed, c)`
  - function `lfsr_step(x)`
- Sub-module `random_state_channel`: one counter, one LFSR, the draw logic and one output bit. The top instantiates it with a generate loop and distributes the package-derived seeds.

## Test plan
- Reset, FIXED mode, defaults, `i_en` = 1 → every channel gives exactly 10 cycles 0, then 30 cycles 1, repeating. `o_toggle` pulses at cycles 10, 40, 50, 80…
- RANDOM mode, 100k cycles → every LOW run is in [10,20] and every HIGH run is in [30,40]. Run lengths match a reference model using `lfsr_step`/`derive_seed` exactly. Channels differ from each other.
- Two resets with the same SEED → identical `o_state` traces. With `SEED` = 0 and `CHANNELS` = 1, the channel uses seed 1.
- Toggle `i_en` low for 7 cycles mid-phase → the phase is stretched by exactly 7 cycles, and `o_toggle` stays 0 during the freeze.
- FORCE_HIGH at cycle 5 after reset → `o_state` = all ones at cycle 6 with `o_toggle` all ones. Return to FIXED → the HIGH phase lasts 30 cycles, then LOW for 10.
- Set `STATE_1_MIN_VAL` = STATE_1_MAX_VAL = 1 → alternating 1-cycle HIGH pulses. Set `STATE_0_MIN_VAL` > `STATE_0_MAX_VAL` → elaboration error.
